fp_adder_arbiter: RTL and testbench
===================================

Name: fp_adder_arbiter

Overview:
Shares one fixed-latency pipelined floating-point adder between NUM_REQ requesters using round-robin arbitration. Each accepted operation carries a requester tag through a shift register matched to the adder latency, so every result is returned to the requester that issued it. A drain handshake quiesces the adder for reconfiguration or flush, and the block flags any adder output that has no matching tag. Sits between the layer datapath engines and the shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width (IEEE-754 single)
ADD_LAT, 6, adder valid_in-to-valid_out latency in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; operands must be held until gnt
req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
gnt  out  NUM_REQ  one-hot, one-cycle pulse; operation accepted this cycle
add_valid_in  out  1  to adder
add_a  out  DATA_W  to adder
add_b  out  DATA_W  to adder
add_valid_out  in  1  from adder
add_result  in  DATA_W  from adder
resp_valid  out  NUM_REQ  one-hot result strobe
resp_data  out  DATA_W  result, valid when any resp_valid bit is set
drain_req  in  1  level; stop issuing and empty the adder
drain_ack  out  1  high while in DRAINED
busy  out  1  in-flight count nonzero
err_tag  out  1  sticky: adder output with no tag in flight

Behaviour:
- Reset: gnt, add_valid_in, add_a, add_b, resp_valid, resp_data, drain_ack, busy and err_tag are 0. Tag pipe is cleared, the round-robin pointer is set to 0 and the state goes to ACTIVE. Reset mid-operation discards all in-flight tags. Adder outputs arriving afterwards set err_tag.
- Arbitration (combinational select, registered outputs): in ACTIVE, grant the first requester with req high, searching from the pointer upward with wrap. The following all register in the same edge:
  - gnt[w] pulses.
  - add_valid_in is set to 1.
  - add_a and add_b take requester w's operands.
  - The pointer moves to (w+1) mod NUM_REQ.
- Issue and grant are therefore the same cycle, and the block issues at most one operation per cycle. With no request, or outside ACTIVE, add_valid_in=0 and the operands hold their last values.
- Requester rule: after seeing gnt high, a requester drops req or presents the next operands in the following cycle. A req still high in the cycle gnt is seen is treated as a new request. This allows back-to-back issue at one per cycle from a single requester when no other requester is active.
- Tag pipe: ADD_LAT entries of {valid, id}, advanced every cycle. Entry 0 loads {add_valid_in, winner id} at the same edge that drives the adder, so its tail aligns with add_valid_out.
- Response, registered, 1 cycle after add_valid_out:
  - Tail valid: resp_valid[id] pulses and resp_data = add_result. Total latency from gnt to resp_valid is ADD_LAT+1 cycles.
  - add_valid_out with tail invalid: err_tag is set (cleared only by rst) and no resp_valid is produced.
  - Tail valid without add_valid_out: err_tag is set and the tag is dropped.
- In-flight counter, width clog2(ADD_LAT+1)+1:
  - +1 on issue, -1 on tail valid, unchanged when both happen.
  - Never exceeds ADD_LAT.
  - busy = (count != 0).
- FSM:
  - ACTIVE: on drain_req=1, go to DRAINING. No grant is issued in the cycle drain_req is first sampled.
  - DRAINING: no grants. When count==0 and no response is pending, go to DRAINED. If drain_req drops, return to ACTIVE.
  - DRAINED: drain_ack=1 (registered). When drain_req=0, go to ACTIVE, with drain_ack low the same cycle.
  - If drain_req is asserted while the pipe is already empty, ACTIVE→DRAINING→DRAINED takes 2 cycles.
- Simultaneous drain_req and req: drain wins and req is left pending, no gnt.

Optional Feature:
FP_ARB_STATS_EN. When defined, adds the following read-only outputs:
- stat_issued, 32 bits: count of issues.
- stat_stall, 32 bits: cycles with any req high but no gnt.
- stat_max_inflight: peak in-flight count.
All three clear on rst and saturate at all-ones. When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Test Plan:
- NUM_REQ=4, ADD_LAT=6: only req[2] is held high with changing operands for 5 cycles. Expect gnt[2] on 5 consecutive cycles and resp_valid[2] 7 cycles after each gnt, in order.
- All four req held high, pointer=0 after reset. Expect gnt order 0,1,2,3,0 on consecutive cycles and each response routed to the matching id.
- req[1] with a=0x3F800000, b=0x40000000, adder model returning 0x40400000. Expect resp_valid=0010 and resp_data=0x40400000 at gnt+7.
- Issue 3 operations, then raise drain_req. Expect no gnt while drain_req is high, drain_ack after the last response plus 1 cycle, busy=0, and a pending req granted 1 cycle after drain_req falls.
- Inject add_valid_out with an empty tag pipe. Expect err_tag=1 next cycle, no resp_valid, err_tag remaining set until rst.
- Assert rst for 1 cycle with 4 ops in flight. Expect all outputs 0 next cycle, no resp_valid for the flushed ops, and err_tag=1 when their stale adder outputs arrive.

Source files
------------

// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter
//   Shares one fixed-latency pipelined FP adder between NUM_REQ requesters.
//   Arbitration is round-robin. Each accepted operation carries its requester
//   id down a tag pipe that is matched to the adder latency, so every result
//   goes back to the requester that issued it. A drain handshake lets the
//   adder be emptied before reconfiguration or flush. Any adder output that
//   does not line up with an in-flight tag sets a sticky error flag.
//
//   Optional build macro: FP_ARB_STATS_EN (adds the stat_* outputs).
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   req                per-requester request level, operands held until gnt
//   req_a, req_b       packed operands, requester i at [i*DATA_W +: DATA_W]
//   gnt                one-hot single-cycle grant, registered
//   add_valid_in       issue strobe to the adder
//   add_a, add_b       operands to the adder
//   add_valid_out      result strobe from the adder
//   add_result         result from the adder
//   resp_valid         one-hot result strobe to the requesters
//   resp_data          result data, valid while any resp_valid bit is set
//   drain_req          level: stop issuing and empty the adder
//   drain_ack          high while the block is drained
//   busy               operations are in flight
//   err_tag            sticky: adder output without a matching tag
//   stat_issued        (FP_ARB_STATS_EN) saturating issue count
//   stat_stall         (FP_ARB_STATS_EN) saturating count of stalled cycles
//   stat_max_inflight  (FP_ARB_STATS_EN) peak in-flight count
module fp_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      add_valid_in,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    input  logic                      add_valid_out,
    input  logic [DATA_W-1:0]         add_result,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      drain_req,
    output logic                      drain_ack,
    output logic                      busy,
    output logic                      err_tag
`ifdef FP_ARB_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_stall,
    output logic [$clog2(ADD_LAT+1):0] stat_max_inflight
`endif
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ADD_LAT + 1) + 1;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAINING,
        DRAINED
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_next;
    logic [ID_W-1:0]     scan_id;
    logic [ID_W-1:0]     win_id;
    logic                win_found;
    logic [DATA_W-1:0]   win_a;
    logic [DATA_W-1:0]   win_b;
    logic                issue;
    logic [NUM_REQ-1:0]  gnt_next;
    logic                drain_ack_next;

    logic [ID_W-1:0]     gnt_id;
    logic [CNT_W-1:0]    count;

    logic                tag_v  [ADD_LAT];
    logic [ID_W-1:0]     tag_id [ADD_LAT];
    logic                tail_v;
    logic [ID_W-1:0]     tail_id;
    logic [NUM_REQ-1:0]  tail_hot;

    // ------------------------------------------------------------------
    // Round-robin select: first requesting index at or above ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_id   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!win_found && req[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = req_a[i*DATA_W +: DATA_W];
                win_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    assign tail_v  = tag_v[ADD_LAT-1];
    assign tail_id = tag_id[ADD_LAT-1];

    always_comb begin
        tail_hot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tail_hot[i] = (tail_id == ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACTIVE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Drain completes once no tag is in flight and the
    // adder is not presenting anything this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE: begin
                if (drain_req) begin
                    state_next = DRAINING;
                end
            end
            DRAINING: begin
                if (!drain_req) begin
                    state_next = ACTIVE;
                end else if ((count == '0) && !add_valid_out) begin
                    state_next = DRAINED;
                end
            end
            DRAINED: begin
                if (!drain_req) begin
                    state_next = ACTIVE;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values for the registered outputs). drain_req
    // blocks issue even in the first ACTIVE cycle it is seen.
    // ------------------------------------------------------------------
    always_comb begin
        issue          = (state == ACTIVE) && !drain_req && win_found;
        drain_ack_next = (state_next == DRAINED);
        gnt_next       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_next[i] = issue && (win_id == ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Issue, tag pipe, response and bookkeeping registers.
    // Tag entry 0 loads from the registered issue strobe, so the tail entry
    // is valid in the same cycle the adder presents that operation's result.
    // The in-flight count tracks the tag pipe occupancy and therefore can
    // never exceed ADD_LAT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            add_valid_in <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            gnt_id       <= '0;
            ptr          <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            count        <= '0;
            err_tag      <= 1'b0;
            drain_ack    <= 1'b0;
            for (int unsigned k = 0; k < ADD_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            gnt          <= gnt_next;
            add_valid_in <= issue;
            drain_ack    <= drain_ack_next;
            if (issue) begin
                add_a  <= win_a;
                add_b  <= win_b;
                gnt_id <= win_id;
                ptr    <= ptr_next;
            end

            tag_v[0]  <= add_valid_in;
            tag_id[0] <= gnt_id;
            for (int unsigned k = 1; k < ADD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            resp_valid <= '0;
            if (add_valid_out && tail_v) begin
                resp_valid <= tail_hot;
                resp_data  <= add_result;
            end
            if (add_valid_out != tail_v) begin
                err_tag <= 1'b1;
            end

            case ({add_valid_in, tail_v})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign busy = (count != '0);

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued       <= '0;
            stat_stall        <= '0;
            stat_max_inflight <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 1'b1;
            end
            if ((|req) && !issue && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
            if (count > stat_max_inflight) begin
                stat_max_inflight <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter
//   Directed self-checking bench for fp_adder_arbiter (NUM_REQ=4, ADD_LAT=6).
//   A behavioural adder with matching latency sits on the adder side; it is
//   not reset, so results of flushed operations still emerge after rst.
module tb_fp_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ADD_LAT = 6;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        gnt;
    logic                      add_valid_in;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic                      add_valid_out;
    logic [DATA_W-1:0]         add_result;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      drain_req;
    logic                      drain_ack;
    logic                      busy;
    logic                      err_tag;
    logic                      inj;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_adder_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .ADD_LAT(ADD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt          (gnt),
        .add_valid_in (add_valid_in),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_valid_out(add_valid_out),
        .add_result   (add_result),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .drain_req    (drain_req),
        .drain_ack    (drain_ack),
        .busy         (busy),
        .err_tag      (err_tag)
    );

    // Toy adder: exact for 1.0 + 2.0, a distinctive mix otherwise.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [31:0] opa(input int p, input int n);
        return 32'(32'h1000_0000 + p * 4096 + n);
    endfunction

    function automatic logic [31:0] opb(input int p, input int n);
        return 32'(32'h0200_0000 + p * 16 + n * 3);
    endfunction

    logic        pv [ADD_LAT] = '{default: 1'b0};
    logic [31:0] pa [ADD_LAT] = '{default: 32'h0};
    logic [31:0] pb [ADD_LAT] = '{default: 32'h0};

    always @(posedge clk) begin
        pv[0] <= add_valid_in;
        pa[0] <= add_a;
        pb[0] <= add_b;
        for (int k = 1; k < ADD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end

    assign add_valid_out = pv[ADD_LAT-1] | inj;
    assign add_result    = fp_model(pa[ADD_LAT-1], pb[ADD_LAT-1]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b);
        req_a[p*DATA_W +: DATA_W] = a;
        req_b[p*DATA_W +: DATA_W] = b;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req       = '0;
        drain_req = 1'b0;
        inj       = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_a = '0;
        req_b = '0;
        do_reset(8);
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (add_valid_in !== 1'b0) begin errors++; $display("FAIL reset_add_valid_in: got %b want 0", add_valid_in); end
        checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", add_a, add_b); end
        checks++; if (resp_valid !== 4'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp: got %b/%h want 0000/0", resp_valid, resp_data); end
        checks++; if (drain_ack !== 1'b0 || busy !== 1'b0 || err_tag !== 1'b0) begin errors++; $display("FAIL reset_flags: got ack=%b busy=%b err=%b want 0,0,0", drain_ack, busy, err_tag); end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [3:0] eg, er;
        do_reset(1);
        k = 0;
        set_ops(2, opa(2, 0), opb(2, 0));
        req = 4'b0100;
        for (int t = 1; t <= 13; t++) begin
            tick();
            eg = (t <= 5) ? 4'b0100 : 4'b0000;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL b2b_gnt t=%0d: got %b want %b", t, gnt, eg); end
            if (t <= 5) begin
                checks++;
                if (add_valid_in !== 1'b1 || add_a !== opa(2, t-1) || add_b !== opb(2, t-1)) begin
                    errors++; $display("FAIL b2b_issue t=%0d: got v=%b a=%h b=%h want 1 %h %h", t, add_valid_in, add_a, add_b, opa(2, t-1), opb(2, t-1));
                end
            end
            er = (t >= 8 && t <= 12) ? 4'b0100 : 4'b0000;
            checks++; if (resp_valid !== er) begin errors++; $display("FAIL b2b_resp_valid t=%0d: got %b want %b", t, resp_valid, er); end
            if (er != 4'b0) begin
                checks++;
                if (resp_data !== fp_model(opa(2, t-8), opb(2, t-8))) begin
                    errors++; $display("FAIL b2b_resp_data t=%0d: got %h want %h", t, resp_data, fp_model(opa(2, t-8), opb(2, t-8)));
                end
            end
            if (gnt[2]) begin
                k++;
                if (k == 5) req = '0;
                else set_ops(2, opa(2, k), opb(2, k));
            end
        end
    endtask

    task automatic test_round_robin();
        int n [4];
        int e_id [5] = '{0, 1, 2, 3, 0};
        int e_n  [5] = '{0, 0, 0, 0, 1};
        logic [3:0] eg, er;
        logic [31:0] ed;
        do_reset(1);
        for (int p = 0; p < 4; p++) begin
            n[p] = 0;
            set_ops(p, opa(p, 0), opb(p, 0));
        end
        req = 4'b1111;
        for (int t = 1; t <= 13; t++) begin
            tick();
            eg = '0;
            if (t <= 5) eg[e_id[t-1]] = 1'b1;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt t=%0d: got %b want %b", t, gnt, eg); end
            er = '0;
            ed = '0;
            if (t >= 8 && t <= 12) begin
                er[e_id[t-8]] = 1'b1;
                ed = fp_model(opa(e_id[t-8], e_n[t-8]), opb(e_id[t-8], e_n[t-8]));
            end
            checks++; if (resp_valid !== er) begin errors++; $display("FAIL rr_resp_valid t=%0d: got %b want %b", t, resp_valid, er); end
            if (er != 4'b0) begin
                checks++; if (resp_data !== ed) begin errors++; $display("FAIL rr_resp_data t=%0d: got %h want %h", t, resp_data, ed); end
            end
            for (int p = 0; p < 4; p++) begin
                if (gnt[p]) begin
                    n[p]++;
                    set_ops(p, opa(p, n[p]), opb(p, n[p]));
                end
            end
            if (t == 5) req = '0;
        end
    endtask

    task automatic test_known_value();
        set_ops(1, 32'h3F80_0000, 32'h4000_0000);
        req = 4'b0010;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) begin
                checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL kv_gnt: got %b want 0010", gnt); end
                req = '0;
            end
            if (t == 7) begin
                checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL kv_early_resp: got %b want 0000", resp_valid); end
            end
            if (t == 8) begin
                checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL kv_resp_valid: got %b want 0010", resp_valid); end
                checks++; if (resp_data !== 32'h4040_0000) begin errors++; $display("FAIL kv_resp_data: got %h want 40400000", resp_data); end
            end
        end
    endtask

    task automatic test_drain();
        int k;
        logic [3:0] eg, er;
        logic ea;
        k = 0;
        set_ops(0, opa(0, 0), opb(0, 0));
        req = 4'b0001;
        for (int t = 1; t <= 22; t++) begin
            tick();
            eg = (t <= 3) ? 4'b0001 : ((t == 15) ? 4'b1000 : 4'b0000);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL drain_gnt t=%0d: got %b want %b", t, gnt, eg); end
            er = (t >= 8 && t <= 10) ? 4'b0001 : ((t == 22) ? 4'b1000 : 4'b0000);
            checks++; if (resp_valid !== er) begin errors++; $display("FAIL drain_resp_valid t=%0d: got %b want %b", t, resp_valid, er); end
            if (t >= 8 && t <= 10) begin
                checks++;
                if (resp_data !== fp_model(opa(0, t-8), opb(0, t-8))) begin
                    errors++; $display("FAIL drain_resp_data t=%0d: got %h want %h", t, resp_data, fp_model(opa(0, t-8), opb(0, t-8)));
                end
            end
            if (t == 22) begin
                checks++; if (resp_data !== fp_model(opa(3, 0), opb(3, 0))) begin errors++; $display("FAIL drain_pending_data: got %h want %h", resp_data, fp_model(opa(3, 0), opb(3, 0))); end
            end
            ea = (t >= 11 && t <= 13);
            checks++; if (drain_ack !== ea) begin errors++; $display("FAIL drain_ack t=%0d: got %b want %b", t, drain_ack, ea); end
            if (t == 4) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_hi: got %b want 1", busy); end
            end
            if (t == 11) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_lo: got %b want 0", busy); end
            end
            if (t <= 3 && gnt[0]) begin
                k++;
                set_ops(0, opa(0, k), opb(0, k));
            end
            if (t == 3) begin
                set_ops(3, opa(3, 0), opb(3, 0));
                req       = 4'b1000;
                drain_req = 1'b1;
            end
            if (t == 13) drain_req = 1'b0;
            if (t == 15) req = '0;
        end
    endtask

    task automatic test_err_tag();
        checks++; if (err_tag !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", err_tag); end
        inj = 1'b1;
        tick();
        inj = 1'b0;
        checks++; if (err_tag !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_tag); end
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL err_no_resp: got %b want 0000", resp_valid); end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++; if (err_tag !== 1'b1) begin errors++; $display("FAIL err_sticky t=%0d: got %b want 1", t, err_tag); end
        end
    endtask

    task automatic test_reset_flush();
        logic [3:0] eg;
        logic ee;
        do_reset(1);
        checks++; if (err_tag !== 1'b0) begin errors++; $display("FAIL flush_err_cleared: got %b want 0", err_tag); end
        for (int p = 0; p < 4; p++) set_ops(p, opa(p, 8), opb(p, 8));
        req = 4'b1111;
        for (int t = 1; t <= 4; t++) begin
            tick();
            eg = '0;
            eg[t-1] = 1'b1;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL flush_gnt t=%0d: got %b want %b", t, gnt, eg); end
        end
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (gnt !== 4'b0 || add_valid_in !== 1'b0) begin errors++; $display("FAIL flush_issue: got gnt=%b v=%b want 0000,0", gnt, add_valid_in); end
        checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin errors++; $display("FAIL flush_operands: got %h/%h want 0/0", add_a, add_b); end
        checks++; if (resp_valid !== 4'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL flush_resp: got %b/%h want 0000/0", resp_valid, resp_data); end
        checks++; if (busy !== 1'b0 || drain_ack !== 1'b0 || err_tag !== 1'b0) begin errors++; $display("FAIL flush_flags: got busy=%b ack=%b err=%b want 0,0,0", busy, drain_ack, err_tag); end
        for (int t = 6; t <= 12; t++) begin
            tick();
            checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL flush_stale_resp t=%0d: got %b want 0000", t, resp_valid); end
            ee = (t >= 8);
            checks++; if (err_tag !== ee) begin errors++; $display("FAIL flush_err t=%0d: got %b want %b", t, err_tag, ee); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_round_robin();
        test_known_value();
        test_drain();
        test_err_tag();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
